muldiv_sequencer: RTL and testbench

- Iterative multiply/divide controller that owns the architectural hi/lo registers for the single-issue core.
- Accepts MULT/MULTU/DIV/DIVU from decode and runs a radix-2 shift-add / restoring-divide loop over WIDTH cycles.
- Holds busy high so the PC/fetch logic stalls; writes hi/lo atomically on completion.
- Also services direct hi/lo writes (MTHI/MTLO) when idle.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural hi/lo pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           is_div, is_div_nxt;
  logic           neg_q, neg_q_nxt;
  logic           neg_r, neg_r_nxt;
  logic           dz, dz_nxt;
  logic [PW-1:0]  acc, acc_nxt;
  logic [PW-1:0]  b, b_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic           busy_nxt, done_nxt, dbz_nxt;

  logic             op_signed;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH:0]   rem_sh, diff;
  logic [PW-1:0]    prod_fix;
  logic             run_exit;

  assign op_signed = ~op[0];
  assign abs_rs    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign abs_rt    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Restoring-divide step: remainder lives in acc low half, dividend/quotient shifts through q.
  assign rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b[WIDTH-1:0]};

  assign prod_fix = neg_q ? -acc : acc;

`ifdef MULDIV_EARLY_OUT_EN
  assign run_exit = (cnt == '0) || (!is_div && ((q >> 1) == '0));
`else
  assign run_exit = (cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      b           <= '0;
      q           <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      is_div      <= is_div_nxt;
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
      dz          <= dz_nxt;
      acc         <= acc_nxt;
      b           <= b_nxt;
      q           <= q_nxt;
      hi          <= hi_nxt;
      lo          <= lo_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    is_div_nxt = is_div;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    dz_nxt     = dz;
    acc_nxt    = acc;
    b_nxt      = b;
    q_nxt      = q;
    hi_nxt     = hi;
    lo_nxt     = lo;

    if (state != IDLE && flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_hi) hi_nxt = wr_data;
          if (wr_lo) lo_nxt = wr_data;
          if (start && !flush) begin
            is_div_nxt = op[1];
            neg_q_nxt  = op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r_nxt  = op_signed & op[1] & rs_val[WIDTH-1];
            acc_nxt    = '0;
            q_nxt      = op[1] ? abs_rs : abs_rt;
            b_nxt      = {{WIDTH{1'b0}}, (op[1] ? abs_rt : abs_rs)};
            if (op[1] && rt_val == '0) begin
              dz_nxt    = 1'b1;
              state_nxt = DONE;
            end else begin
              dz_nxt    = 1'b0;
              cnt_nxt   = CW'(WIDTH - 1);
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            if (!diff[WIDTH]) begin
              acc_nxt = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
              acc_nxt = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
              q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (q[0]) acc_nxt = acc + b;
            b_nxt = b << 1;
            q_nxt = q >> 1;
          end
          cnt_nxt = cnt - CW'(1);
          if (run_exit) state_nxt = FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            lo_nxt = neg_q ? -q : q;
            hi_nxt = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end else begin
            {hi_nxt, lo_nxt} = prod_fix;
          end
          state_nxt = DONE;
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    dbz_nxt  = (state_nxt == DONE) && dz_nxt;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        flush, wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  int          n;
  logic        dz_seen, bsy_ok;
  logic [31:0] hi1;
  int          done_cnt;
  logic        busy_any;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EXP_Z = 3;
  localparam int EXP_1 = 3;
`else
  localparam int EXP_Z = 34;
  localparam int EXP_1 = 34;
`endif

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op and wait for done; n is the cycle (1 = cycle after the start edge) where done shows.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] c,
                        input int poke, input logic wr,
                        output int cyc, output logic dzs, output logic bok, output logic [31:0] h1);
    @(negedge clk);
    op = o; rs_val = a; rt_val = c; start = 1'b1; wr_hi = wr; wr_lo = wr;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    cyc = 1; bok = 1'b1; h1 = hi;
    while (!done && cyc < 100) begin
      if (!busy) bok = 1'b0;
      if (cyc == poke) begin
        start = 1'b1; op = 2'd3; rs_val = 32'd100; rt_val = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (!busy) bok = 1'b0;
    dzs = div_by_zero;
    if (!done) chk("timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("idle_after", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("multu_lat", 64'(n), 64'd34);
    chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    chk("multu_busy", 64'(bsy_ok), 64'd1);
    chk("multu_dz", 64'(dz_seen), 64'd0);

    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("div_neg_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_lat", 64'(n), 64'd34);

    run_op(2'd3, 32'd7, 32'd2, 5, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("divu_res", {hi, lo}, {32'd1, 32'd3});
    chk("divu_poke_lat", 64'(n), 64'd34);
    chk("divu_poke_dz", 64'(dz_seen), 64'd0);

    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("div_ovf_res", {hi, lo}, {32'd0, 32'h80000000});

    @(negedge clk);
    wr_data = 32'h12345678; wr_hi = 1'b1; wr_lo = 1'b1;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("wr_both", {hi, lo}, 64'h12345678_12345678);

    run_op(2'd3, 32'd5, 32'd0, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("dz_lat", 64'(n), 64'd1);
    chk("dz_flag", 64'(dz_seen), 64'd1);
    chk("dz_hilo", {hi, lo}, 64'h12345678_12345678);

    wr_data = 32'hDEADBEEF;
    run_op(2'd1, 32'd2, 32'd3, 0, 1'b1, n, dz_seen, bsy_ok, hi1);
    chk("wr_start_mid", 64'(hi1), 64'hDEADBEEF);
    chk("wr_start_res", {hi, lo}, {32'd0, 32'd6});

    // Flush at RUN cycle 10 with a coincident start.
    @(negedge clk);
    op = 2'd1; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_flags", {62'd0, busy, done}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'd0, 32'd6});
    done_cnt = 0; busy_any = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_any = 1'b1;
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_no_busy", 64'(busy_any), 64'd0);

    // Reset in the middle of RUN.
    @(negedge clk);
    op = 2'd1; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_flags", {62'd0, busy, done}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);

    run_op(2'd1, 32'd9, 32'd0, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("mul_zero_lat", 64'(n), 64'(EXP_Z));
    chk("mul_zero_res", {hi, lo}, 64'd0);

    run_op(2'd1, 32'd9, 32'd1, 0, 1'b0, n, dz_seen, bsy_ok, hi1);
    chk("mul_one_lat", 64'(n), 64'(EXP_1));
    chk("mul_one_res", {hi, lo}, 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
